// File: rtl/id_operand_stage.sv
// Decode-stage operand core: fs->ds pipeline register, regfile addressing, operand bypass
// selection, load-use interlock, stall accounting and branch gating toward fetch.
module id_operand_stage #(
    parameter int XLEN        = 32,
    parameter int RA_W        = 5,
    parameter int NUM_FWD     = 3,
    parameter int BYPASS_EN   = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      fs_to_ds_valid,
    input  logic [31:0]               fs_inst,
    input  logic [XLEN-1:0]           fs_pc,
    output logic                      ds_allowin,
    input  logic                      es_allowin,
    output logic                      ds_to_es_valid,
    output logic [31:0]               ds_inst,
    output logic [XLEN-1:0]           ds_pc,
    input  logic                      use_rj,
    input  logic                      use_rkd,
    input  logic                      src_reg_is_rd,
    input  logic                      br_taken_raw,
    output logic                      br_taken,
    output logic [RA_W-1:0]           rf_raddr1,
    output logic [RA_W-1:0]           rf_raddr2,
    input  logic [XLEN-1:0]           rf_rdata1,
    input  logic [XLEN-1:0]           rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*RA_W-1:0]   fwd_dest,
    input  logic [NUM_FWD-1:0]        fwd_data_ok,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    output logic [XLEN-1:0]           rj_value,
    output logic [XLEN-1:0]           rkd_value,
    input  logic                      stall_clr,
    output logic [STALL_CNT_W-1:0]    stall_cnt
);

    // Handshake: an instruction moves ds->es on a cycle where ds_to_es_valid & es_allowin,
    // and fs->ds on a cycle where fs_to_ds_valid & ds_allowin. Neither side may retract.

    typedef struct packed {
        logic            hit;
        logic            ok;
        logic [XLEN-1:0] data;
    } fwd_pick_t;

    logic ds_valid;
    logic ds_ready_go;
    logic hazard_rj;
    logic hazard_rkd;

    fwd_pick_t rj_pick;
    fwd_pick_t rkd_pick;
    logic      rj_active;
    logic      rkd_active;

    // Youngest matching producer wins; older in-flight writes to the same register are stale.
    function automatic fwd_pick_t pick_source(input logic [RA_W-1:0] addr);
        fwd_pick_t p;
        p = '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!p.hit && fwd_valid[i] && fwd_we[i] && (fwd_dest[i*RA_W +: RA_W] == addr)) begin
                p.hit  = 1'b1;
                p.ok   = fwd_data_ok[i];
                p.data = fwd_data[i*XLEN +: XLEN];
            end
        end
        return p;
    endfunction

    assign rf_raddr1 = ds_inst[5 +: RA_W];
    assign rf_raddr2 = src_reg_is_rd ? ds_inst[0 +: RA_W] : ds_inst[10 +: RA_W];

    always_comb begin
        rj_pick    = pick_source(rf_raddr1);
        rkd_pick   = pick_source(rf_raddr2);
        rj_active  = use_rj  && (rf_raddr1 != '0) && rj_pick.hit;
        rkd_active = use_rkd && (rf_raddr2 != '0) && rkd_pick.hit;
    end

    always_comb begin
        hazard_rj  = 1'b0;
        hazard_rkd = 1'b0;
        if (BYPASS_EN != 0) begin
            hazard_rj  = rj_active  && !rj_pick.ok;
            hazard_rkd = rkd_active && !rkd_pick.ok;
        end else begin
            hazard_rj  = rj_active;
            hazard_rkd = rkd_active;
        end
    end

    // Register 0 is hard-wired to zero regardless of what the regfile port returns.
    always_comb begin
        rj_value  = rf_rdata1;
        rkd_value = rf_rdata2;
        if (rf_raddr1 == '0) begin
            rj_value = '0;
        end else if ((BYPASS_EN != 0) && rj_active && rj_pick.ok) begin
            rj_value = rj_pick.data;
        end
        if (rf_raddr2 == '0) begin
            rkd_value = '0;
        end else if ((BYPASS_EN != 0) && rkd_active && rkd_pick.ok) begin
            rkd_value = rkd_pick.data;
        end
    end

    assign ds_ready_go    = !(hazard_rj || hazard_rkd);
    assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid && ds_ready_go;
    assign br_taken       = br_taken_raw && ds_valid && ds_ready_go && es_allowin;

    // A taken branch kills whatever fetch is presenting this cycle (wrong path).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid <= 1'b0;
        end else if (br_taken) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= fs_to_ds_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_inst <= '0;
            ds_pc   <= '0;
        end else if (fs_to_ds_valid && ds_allowin) begin
            ds_inst <= fs_inst;
            ds_pc   <= fs_pc;
        end
    end

    // Counts hazard cycles only; es back-pressure with ready operands is not a stall here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (ds_valid && !ds_ready_go && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
